// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART transmitter and receiver: the frame state
// enumeration, parity-type encodings and the default data width.
// -----------------------------------------------------------------------------
package uart_pkg;

    // Default number of data bits per frame.
    localparam int unsigned DATA_W_DEFAULT = 8;

    // PAR_TYP encodings: even parity counts ones including the parity bit.
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Frame phases, in transmission order.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// -----------------------------------------------------------------------------
// uart_tx_bit_timer
// Bit-period timer for the UART transmitter. edge_cnt runs 0..prescale-1 while
// a frame is active; bit_done strobes on the last clock of every bit period.
// bit_cnt counts completed data bits while count_bit is high.
// A prescale value of 0 gives a bit period of 2**PRESC_W clocks (64 by default).
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   clear      in   restart both counters at the beginning of a frame
//   run        in   frame in progress, advance edge_cnt
//   count_bit  in   advance bit_cnt when a bit period completes
//   prescale   in   clocks per bit (latched copy owned by the caller)
//   bit_done   out  last clock of the current bit period
//   bit_cnt    out  index of the data bit currently on the line
// -----------------------------------------------------------------------------
module uart_tx_bit_timer #(
    parameter int unsigned PRESC_W = 6,
    parameter int unsigned BIT_W   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               run,
    input  logic               count_bit,
    input  logic [PRESC_W-1:0] prescale,
    output logic               bit_done,
    output logic [BIT_W-1:0]   bit_cnt
);

    logic [PRESC_W-1:0] edge_cnt;
    logic [PRESC_W-1:0] edge_last;

    // Subtracting one wraps prescale==0 to all-ones, which yields the
    // 2**PRESC_W-clock period without a separate special case.
    assign edge_last = prescale - PRESC_W'(1);
    assign bit_done  = run && (edge_cnt == edge_last);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (clear) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (run) begin
            if (bit_done) begin
                edge_cnt <= '0;
                if (count_bit) begin
                    bit_cnt <= bit_cnt + BIT_W'(1);
                end
            end else begin
                edge_cnt <= edge_cnt + PRESC_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// UART transmitter. Sends one word per frame: start bit (0), data LSB first,
// optional parity bit, one stop bit (1). Every bit lasts `prescale` clocks
// (0 means 64). Word and configuration are latched when a word is accepted,
// so input changes during a frame only affect later frames.
//
// Build option
//   UART_TX_HOLD_BUF_EN  adds a one-entry holding register so a word can be
//                        queued during a frame and sent with no idle gap.
//                        Without it, ready is high only when idle and
//                        consecutive frames are separated by one idle cycle.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-low reset
//   P_DATA      in   word to send, captured on accept
//   DATA_VALID  in   word request (accepted when ready is high)
//   ready       out  a word can be accepted this cycle
//   PAR_EN      in   insert a parity bit after the last data bit
//   PAR_TYP     in   0 = even parity, 1 = odd parity
//   prescale    in   clocks per bit, 0 means 64
//   TX_OUT      out  serial line, registered, idles high
//   busy        out  high from the first start-bit clock to the last stop-bit clock
// -----------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEFAULT,
    parameter int unsigned PRESC_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DATA_W-1:0]  P_DATA,
    input  logic               DATA_VALID,
    output logic               ready,
    input  logic               PAR_EN,
    input  logic               PAR_TYP,
    input  logic [PRESC_W-1:0] prescale,
    output logic               TX_OUT,
    output logic               busy
);

    localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    uart_state_t        state;
    uart_state_t        state_nxt;

    // Active frame: shift register (current data bit in bit 0) and config.
    logic [DATA_W-1:0]  data_q;
    logic               par_bit_q;
    logic               par_en_q;
    logic [PRESC_W-1:0] presc_q;

    logic               tx_nxt;
    logic               accept;
    logic               load;
    logic               shift;

    // Source of the next frame (inputs, or the holding register).
    logic [DATA_W-1:0]  src_data;
    logic               src_par_en;
    logic               src_par_typ;
    logic [PRESC_W-1:0] src_presc;

    logic               bit_done;
    logic [BIT_W-1:0]   bit_cnt;

    assign accept = DATA_VALID && ready;

`ifdef UART_TX_HOLD_BUF_EN
    logic [DATA_W-1:0]  buf_data;
    logic               buf_par_en;
    logic               buf_par_typ;
    logic [PRESC_W-1:0] buf_presc;
    logic               buf_valid;
    logic               load_buf;
    logic               store;

    assign ready = !buf_valid;

    // From IDLE with an empty buffer the word starts immediately; any other
    // accept is parked in the holding register. A store in the same cycle
    // as a drain refills the buffer.
    assign store = accept && (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_valid   <= 1'b0;
            buf_data    <= '0;
            buf_par_en  <= 1'b0;
            buf_par_typ <= 1'b0;
            buf_presc   <= '0;
        end else if (store) begin
            buf_valid   <= 1'b1;
            buf_data    <= P_DATA;
            buf_par_en  <= PAR_EN;
            buf_par_typ <= PAR_TYP;
            buf_presc   <= prescale;
        end else if (load_buf) begin
            buf_valid   <= 1'b0;
        end
    end

    always_comb begin
        src_data    = P_DATA;
        src_par_en  = PAR_EN;
        src_par_typ = PAR_TYP;
        src_presc   = prescale;
        if (load_buf) begin
            src_data    = buf_data;
            src_par_en  = buf_par_en;
            src_par_typ = buf_par_typ;
            src_presc   = buf_presc;
        end
    end
`else
    assign ready       = !busy && (state == IDLE);
    assign src_data    = P_DATA;
    assign src_par_en  = PAR_EN;
    assign src_par_typ = PAR_TYP;
    assign src_presc   = prescale;
`endif

    uart_tx_bit_timer #(
        .PRESC_W (PRESC_W),
        .BIT_W   (BIT_W)
    ) u_bit_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (load),
        .run       (state != IDLE),
        .count_bit (state == DATA),
        .prescale  (presc_q),
        .bit_done  (bit_done),
        .bit_cnt   (bit_cnt)
    );

    // Next state and next line level. TX_OUT is registered, so the level is
    // chosen here on the transition into each bit rather than decoded from
    // the current state.
    always_comb begin
        state_nxt = state;
        tx_nxt    = TX_OUT;
        load      = 1'b0;
        shift     = 1'b0;
`ifdef UART_TX_HOLD_BUF_EN
        load_buf  = 1'b0;
`endif
        case (state)
            IDLE: begin
`ifdef UART_TX_HOLD_BUF_EN
                if (buf_valid) begin
                    load     = 1'b1;
                    load_buf = 1'b1;
                end else if (accept) begin
                    load = 1'b1;
                end
`else
                if (accept) begin
                    load = 1'b1;
                end
`endif
                if (load) begin
                    state_nxt = START;
                    tx_nxt    = 1'b0;
                end
            end
            START: begin
                if (bit_done) begin
                    state_nxt = DATA;
                    tx_nxt    = data_q[0];
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_cnt == BIT_W'(DATA_W - 1)) begin
                        if (par_en_q) begin
                            state_nxt = PARITY;
                            tx_nxt    = par_bit_q;
                        end else begin
                            state_nxt = STOP;
                            tx_nxt    = 1'b1;
                        end
                    end else begin
                        shift  = 1'b1;
                        tx_nxt = data_q[1];
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    state_nxt = STOP;
                    tx_nxt    = 1'b1;
                end
            end
            STOP: begin
                if (bit_done) begin
`ifdef UART_TX_HOLD_BUF_EN
                    if (buf_valid) begin
                        load      = 1'b1;
                        load_buf  = 1'b1;
                        state_nxt = START;
                        tx_nxt    = 1'b0;
                    end else begin
                        state_nxt = IDLE;
                        tx_nxt    = 1'b1;
                    end
`else
                    state_nxt = IDLE;
                    tx_nxt    = 1'b1;
`endif
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            TX_OUT    <= 1'b1;
            busy      <= 1'b0;
            data_q    <= '0;
            par_bit_q <= 1'b0;
            par_en_q  <= 1'b0;
            presc_q   <= '0;
        end else begin
            state  <= state_nxt;
            TX_OUT <= tx_nxt;
            busy   <= (state_nxt != IDLE);
            if (load) begin
                data_q    <= src_data;
                par_bit_q <= (src_par_typ == PAR_ODD) ? ~(^src_data) : (^src_data);
                par_en_q  <= src_par_en;
                presc_q   <= src_presc;
            end else if (shift) begin
                data_q <= data_q >> 1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

`ifdef UART_TX_HOLD_BUF_EN
    localparam logic HAS_BUF = 1'b1;
`else
    localparam logic HAS_BUF = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       ready;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] prescale;
    logic       TX_OUT;
    logic       busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_tx #(
        .DATA_W  (8),
        .PRESC_W (6)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .ready      (ready),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .prescale   (prescale),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag, input int cycles);
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk);
            check1({tag, "_tx"},    TX_OUT, 1'b1);
            check1({tag, "_busy"},  busy,   1'b0);
            check1({tag, "_ready"}, ready,  1'b1);
        end
    endtask

    // Present a word and let it be accepted; returns at the negedge of the
    // first frame cycle with DATA_VALID still high.
    task automatic start(input logic [7:0] d, input logic pe, input logic pt,
                         input logic [5:0] ps, input string tag);
        @(negedge clk);
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        prescale   = ps;
        DATA_VALID = 1'b1;
        check1({tag, "_rdy_pre"}, ready,  1'b1);
        check1({tag, "_tx_pre"},  TX_OUT, 1'b1);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference model: the expected line is the frame's bit list, each bit
    // repeated for the bit period. Starts at the negedge of frame cycle 0
    // and ends at the negedge of the last frame cycle.
    task automatic check_frame(input logic [7:0] d, input logic pe, input logic pt,
                               input logic [5:0] ps, input int dv_off_at,
                               input int scramble_at, input int poke_at,
                               input int abort_at, input int rdy_from,
                               input logic rdy_val, input string tag);
        int   p;
        int   len;
        logic exp_bits[$];
        p = (ps == 6'd0) ? 64 : int'(ps);
        exp_bits = {};
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
        if (pe) exp_bits.push_back(logic'(($countones(d) + int'(pt)) % 2));
        exp_bits.push_back(1'b1);
        len = exp_bits.size() * p;
        for (int k = 0; k < len; k++) begin
            if (k > 0) @(negedge clk);
            if (k == dv_off_at) DATA_VALID = 1'b0;
            if (k == scramble_at) begin
                prescale = 6'($urandom);
                PAR_EN   = 1'($urandom);
                PAR_TYP  = 1'($urandom);
                P_DATA   = 8'($urandom);
            end
            if (poke_at >= 0 && k == poke_at) begin
                DATA_VALID = 1'b1;
                P_DATA     = 8'($urandom);
            end
            if (poke_at >= 0 && k == poke_at + 2) DATA_VALID = 1'b0;
            if (k == abort_at) begin
                rst = 1'b0;
                #1;
                check1({tag, "_abort_tx"},   TX_OUT, 1'b1);
                check1({tag, "_abort_busy"}, busy,   1'b0);
                return;
            end
            check1({tag, "_tx"},   TX_OUT, exp_bits[k / p]);
            check1({tag, "_busy"}, busy,   1'b1);
            if (rdy_from >= 0 && k >= rdy_from) check1({tag, "_ready"}, ready, rdy_val);
        end
    endtask

    initial begin
        logic [7:0] d;
        logic       pe;
        logic       pt;
        logic [5:0] ps;

        rst        = 1'b0;
        DATA_VALID = 1'b0;
        P_DATA     = 8'h00;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        prescale   = 6'd8;

        // Reset state
        #12;
        check1("reset_tx",   TX_OUT, 1'b1);
        check1("reset_busy", busy,   1'b0);
        @(negedge clk);
        rst = 1'b1;
        check_idle("post_reset", 2);

        // 1: 0xA5, prescale 8, no parity
        start(8'hA5, 1'b0, 1'b0, 6'd8, "t1");
        check_frame(8'hA5, 1'b0, 1'b0, 6'd8, 0, -1, -1, -1, 0, HAS_BUF, "t1");
        check_idle("t1_end", 2);

        // 2: 0x07, prescale 16, even then odd parity
        start(8'h07, 1'b1, 1'b0, 6'd16, "t2e");
        check_frame(8'h07, 1'b1, 1'b0, 6'd16, 0, -1, -1, -1, 0, HAS_BUF, "t2e");
        check_idle("t2e_end", 1);
        start(8'h07, 1'b1, 1'b1, 6'd16, "t2o");
        check_frame(8'h07, 1'b1, 1'b1, 6'd16, 0, -1, -1, -1, 0, HAS_BUF, "t2o");
        check_idle("t2o_end", 1);

        // 3: DATA_VALID held across two words
        start(8'h55, 1'b0, 1'b0, 6'd4, "t3a");
        P_DATA = 8'hAA;
`ifdef UART_TX_HOLD_BUF_EN
        check_frame(8'h55, 1'b0, 1'b0, 6'd4, 1, -1, -1, -1, 1, 1'b0, "t3a");
        @(negedge clk);
        check_frame(8'hAA, 1'b0, 1'b0, 6'd4, 0, -1, -1, -1, 0, 1'b1, "t3b");
`else
        check_frame(8'h55, 1'b0, 1'b0, 6'd4, -1, -1, -1, -1, 0, 1'b0, "t3a");
        @(negedge clk);
        check1("t3_gap_tx",    TX_OUT, 1'b1);
        check1("t3_gap_busy",  busy,   1'b0);
        check1("t3_gap_ready", ready,  1'b1);
        @(posedge clk);
        @(negedge clk);
        check_frame(8'hAA, 1'b0, 1'b0, 6'd4, 0, -1, -1, -1, 0, 1'b0, "t3b");
`endif
        check_idle("t3_end", 2);

        // 4: config scrambled mid-frame, next frame uses freshly driven config
        start(8'h3A, 1'b0, 1'b0, 6'd8, "t4a");
        check_frame(8'h3A, 1'b0, 1'b0, 6'd8, 0, 20, -1, -1, 0, HAS_BUF, "t4a");
        check_idle("t4a_end", 1);
        start(8'hC6, 1'b1, 1'b1, 6'd5, "t4b");
        check_frame(8'hC6, 1'b1, 1'b1, 6'd5, 0, 7, -1, -1, 0, HAS_BUF, "t4b");
        check_idle("t4b_end", 1);

        // 5: reset during D3, then clean 0x3C frame
        start(8'hF0, 1'b1, 1'b0, 6'd6, "t5a");
        check_frame(8'hF0, 1'b1, 1'b0, 6'd6, 0, -1, -1, 4 * 6 + 3, 0, HAS_BUF, "t5a");
        repeat (2) @(negedge clk);
        check1("t5_hold_tx",   TX_OUT, 1'b1);
        check1("t5_hold_busy", busy,   1'b0);
        rst = 1'b1;
        check_idle("t5_release", 2);
        start(8'h3C, 1'b0, 1'b0, 6'd6, "t5b");
        check_frame(8'h3C, 1'b0, 1'b0, 6'd6, 0, -1, -1, -1, 0, HAS_BUF, "t5b");
        check_idle("t5b_end", 1);

        // 6: prescale 0 = 64 clocks per bit; request while busy is dropped
        start(8'h81, 1'b0, 1'b0, 6'd0, "t6");
        check_frame(8'h81, 1'b0, 1'b0, 6'd0, 0, -1, HAS_BUF ? -1 : 64 * 3, -1, 0, HAS_BUF, "t6");
        check_idle("t6_end", 4);

        // Random frames, first one at the minimum prescale of 1
        for (int i = 0; i < 8; i++) begin
            d  = 8'($urandom);
            pe = 1'($urandom);
            pt = 1'($urandom);
            ps = (i == 0) ? 6'd1 : 6'($urandom_range(1, 10));
            start(d, pe, pt, ps, "rnd");
            check_frame(d, pe, pt, ps, 0, -1, -1, -1, 0, HAS_BUF, "rnd");
            check_idle("rnd_end", 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
